muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that sits beside the single-cycle ALU in the execute stage and handles MULT, MULTU, DIV and DIVU into a HI/LO result pair. Operands use the same word-wide ports as the ALU. Each operation runs one radix-2 step per cycle behind a start/busy/done handshake, so the hazard unit can stall dependent instructions. A kill input lets the pipeline squash an in-flight operation on a flush.

---
 rtl/muldiv_unit.sv | 146 ++++++++++++++
 tb/tb_muldiv_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit for MULT/MULTU/DIV/DIVU.
// One shift-add or restore step per cycle; results land in HI/LO after a sign fix-up cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] porta,
    input  logic [WIDTH-1:0] portb,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               sign_a, sign_b;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   opnd;

    logic               accept, dbz, neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign accept = (state == IDLE || state == DONE) && start && !kill;
    assign dbz    = op[1] && (portb == '0);
    assign neg_a  = op[0] && porta[WIDTH-1];
    assign neg_b  = op[0] && portb[WIDTH-1];
    assign mag_a  = neg_a ? (~porta + 1'b1) : porta;
    assign mag_b  = neg_b ? (~portb + 1'b1) : portb;

    // Multiply: the low half of acc starts as the multiplier and is consumed LSB first
    // while the product grows into the upper half.
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

    // Divide: dividend sits in the low half of acc and shifts out MSB first; quotient shifts in.
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_sub   = div_shift[WIDTH-1:0] - opnd;

    assign prod_fix  = (sign_a ^ sign_b) ? (~acc + 1'b1) : acc;
    assign quo_fix   = (sign_a ^ sign_b) ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    assign rem_fix   = sign_a ? (~rem + 1'b1) : rem;

    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    always_ff @(posedge CLK) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: begin
                if (kill)       state_n = IDLE;
                else if (start) state_n = dbz ? DONE : CALC;
                else            state_n = IDLE;
            end
            CALC: begin
                if (kill)                        state_n = IDLE;
                else if (cnt == CW'(WIDTH - 1))  state_n = FIX;
            end
            FIX:     state_n = kill ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            acc      <= '0;
            rem      <= '0;
            opnd     <= '0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else begin
            div_zero <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        is_div <= op[1];
                        sign_a <= neg_a;
                        sign_b <= neg_b;
                        cnt    <= '0;
                        rem    <= '0;
                        if (dbz) begin
                            acc      <= '0;
                            opnd     <= '0;
                            hi       <= porta;
                            lo       <= '1;
                            div_zero <= 1'b1;
                        end else if (op[1]) begin
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                            opnd <= mag_b;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        rem <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                        acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], div_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (!kill) begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quo_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed WIDTH=32 cases plus a random WIDTH=8 sweep
// against a plain-arithmetic reference model.
module tb_muldiv_unit;
    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    logic        s32, k32, busy32, done32, dz32;
    logic [1:0]  o32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        s8, k8, busy8, done8, dz8;
    logic [1:0]  o8;
    logic [7:0]  a8, b8, hi8, lo8;

    muldiv_unit #(.WIDTH(32)) u32 (
        .CLK(CLK), .nRST(nRST), .start(s32), .op(o32), .porta(a32), .portb(b32),
        .kill(k32), .busy(busy32), .done(done32), .hi(hi32), .lo(lo32), .div_zero(dz32)
    );
    muldiv_unit #(.WIDTH(8)) u8 (
        .CLK(CLK), .nRST(nRST), .start(s8), .op(o8), .porta(a8), .portb(b8),
        .kill(k8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_zero(dz8)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: signed/unsigned arithmetic on 64-bit integers, truncated to the unit width.
    function automatic void model(input int w, input logic [1:0] o, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] eh,
                                  output logic [63:0] el, output logic ez);
        logic [63:0] m, p;
        longint sa, sb;
        m  = (64'd1 << w) - 64'd1;
        sa = $signed(a << (64 - w)) >>> (64 - w);
        sb = $signed(b << (64 - w)) >>> (64 - w);
        ez = 1'b0;
        if (!o[1]) begin
            p  = o[0] ? 64'(sa * sb) : a * b;
            eh = (p >> w) & m;
            el = p & m;
        end else if (b == 0) begin
            eh = a;
            el = m;
            ez = 1'b1;
        end else if (o[0]) begin
            el = 64'(sa / sb) & m;
            eh = 64'(sa % sb) & m;
        end else begin
            el = (a / b) & m;
            eh = (a % b) & m;
        end
    endfunction

    task automatic run_op(input int w, input logic [1:0] o, input logic [63:0] a,
                          input logic [63:0] b, output logic [63:0] rh, output logic [63:0] rl,
                          output logic rz, output int lat, output int bc);
        bit got = 0;
        if (w == 32) begin o32 = o; a32 = a[31:0]; b32 = b[31:0]; s32 = 1'b1; end
        else         begin o8 = o;  a8 = a[7:0];   b8 = b[7:0];   s8 = 1'b1;  end
        lat = 0; bc = 0; rh = '0; rl = '0; rz = 1'b0;
        while (!got && lat < 200) begin
            @(posedge CLK); #1;
            lat++;
            s32 = 1'b0; s8 = 1'b0;
            if (w == 32 ? busy32 : busy8) bc++;
            if (w == 32 ? done32 : done8) begin
                got = 1;
                rh  = (w == 32) ? {32'b0, hi32} : {56'b0, hi8};
                rl  = (w == 32) ? {32'b0, lo32} : {56'b0, lo8};
                rz  = (w == 32) ? dz32 : dz8;
            end
        end
        chk("done_seen", 64'(got), 64'd1);
    endtask

    task automatic chk_op(input string tag, input int w, input logic [1:0] o,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] eh,
                          input logic [63:0] el, input logic ez, output int bc);
        logic [63:0] rh, rl;
        logic rz;
        int lat;
        run_op(w, o, a, b, rh, rl, rz, lat, bc);
        chk({tag, "_hi"}, rh, eh);
        chk({tag, "_lo"}, rl, el);
        chk({tag, "_dz"}, 64'(rz), 64'(ez));
        chk({tag, "_lat"}, 64'(lat), ez ? 64'd1 : 64'(w + 2));
    endtask

    initial begin
        int bc, lat, dcnt;
        logic [63:0] eh, el, ra, rb;
        logic ez;
        logic [1:0] ro;

        nRST = 1'b0;
        s32 = 0; k32 = 0; o32 = 0; a32 = 0; b32 = 0;
        s8 = 0;  k8 = 0;  o8 = 0;  a8 = 0;  b8 = 0;
        repeat (3) @(posedge CLK);
        #1 nRST = 1'b1;
        chk("rst_busy", 64'(busy32), 0);
        chk("rst_done", 64'(done32), 0);
        chk("rst_hilo", {hi32, lo32}, 0);
        chk("rst_dz", 64'(dz32), 0);

        chk_op("multu_max", 32, 2'b00, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 64'h1, 0, bc);
        chk("multu_busy_cycles", 64'(bc), 64'd33);
        chk_op("mult_neg", 32, 2'b01, 64'hFFFFFFF9, 64'd6, 64'hFFFFFFFF, 64'hFFFFFFD6, 0, bc);
        chk_op("div_neg", 32, 2'b11, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFF, 64'hFFFFFFFD, 0, bc);
        chk_op("divu", 32, 2'b10, 64'd100, 64'd7, 64'd2, 64'd14, 0, bc);
        chk_op("div_ovf", 32, 2'b11, 64'h80000000, 64'hFFFFFFFF, 64'h0, 64'h80000000, 0, bc);
        chk_op("divu_zero", 32, 2'b10, 64'h1234, 64'h0, 64'h1234, 64'hFFFFFFFF, 1, bc);
        @(posedge CLK); #1;

        // start held high through the whole operation with changing operands
        o32 = 2'b10; a32 = 32'd1000; b32 = 32'd3; s32 = 1'b1;
        @(posedge CLK); #1;
        lat = 1; o32 = 2'b00; a32 = 32'd77; b32 = 32'd5;
        while (!done32 && lat < 200) begin @(posedge CLK); #1; lat++; end
        s32 = 1'b0;
        chk("held_lat", 64'(lat), 64'd34);
        chk("held_hi", 64'(hi32), 64'd1);
        chk("held_lo", 64'(lo32), 64'd333);
        @(posedge CLK); #1;

        // kill at counter=10: prior result (1/333) must survive, no done
        o32 = 2'b00; a32 = 32'd5; b32 = 32'd9; s32 = 1'b1;
        @(posedge CLK); #1 s32 = 1'b0;
        repeat (10) @(posedge CLK);
        #1 k32 = 1'b1;
        @(posedge CLK); #1 k32 = 1'b0;
        chk("kill_busy", 64'(busy32), 0);
        chk("kill_hilo", {hi32, lo32}, {32'd1, 32'd333});
        dcnt = 0;
        repeat (40) begin @(posedge CLK); #1; dcnt += int'(done32); end
        chk("kill_no_done", 64'(dcnt), 0);

        // synchronous reset in the middle of CALC
        o32 = 2'b01; a32 = 32'd123; b32 = 32'd456; s32 = 1'b1;
        @(posedge CLK); #1 s32 = 1'b0;
        repeat (5) @(posedge CLK);
        #1 nRST = 1'b0;
        @(posedge CLK); #1;
        chk("midrst_busy", 64'(busy32), 0);
        chk("midrst_done", 64'(done32 | dz32), 0);
        chk("midrst_hilo", {hi32, lo32}, 0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // back-to-back: second start issued in the first one's done cycle
        chk_op("b2b_first", 32, 2'b10, 64'd1000, 64'd10, 64'd0, 64'd100, 0, bc);
        chk_op("b2b_second", 32, 2'b01, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'd0, 64'd1, 0, bc);
        @(posedge CLK); #1;

        // WIDTH=8 random sweep of all four ops
        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 64'($urandom_range(0, 255));
            rb = 64'($urandom_range(0, 255));
            case ($urandom_range(0, 7))
                0: rb = 64'h00;
                1: rb = 64'hFF;
                2: ra = 64'h80;
                default: ;
            endcase
            model(8, ro, ra, rb, eh, el, ez);
            chk_op($sformatf("w8_%0d_op%0d", i, ro), 8, ro, ra, rb, eh, el, ez, bc);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
